d_ff: RTL and testbench



---
 rtl/d_ff.sv | 23 ++
 tb/tb_d_ff.sv | 139 +++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// Single-bit rising-edge D flip-flop with synchronous active-high reset.
// Multi-bit registers are built by replicating this cell in the parent.
module d_ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic q_q;

   // Reset wins over d on the same edge, so an X on d is masked while reset is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a single cell plus a 64-wide generate-replicated register.
`timescale 10ps/1ps
module tb_d_ff;

   logic        clk;
   logic        reset;
   logic        d;
   logic        q;
   logic [63:0] d_arr;
   logic [63:0] q_arr;

   int n_checks;
   int n_fail;

   d_ff dut (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q)
   );

   for (genvar i = 0; i < 64; i++) begin : g_bits
      d_ff u_bit (
         .clk   (clk),
         .reset (reset),
         .d     (d_arr[i]),
         .q     (q_arr[i])
      );
   end

   initial clk = 1'b0;
   always #62.5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      d        = 1'b1;
      d_arr    = 64'd0;

      // Reset dominates d=1.
      tick();
      check("reset_prio", {63'd0, q}, 64'd0);
      check("reset_arr", q_arr, 64'd0);

      // Load 1 and hold for 3 further edges.
      reset = 1'b0;
      d     = 1'b1;
      tick();
      check("load1", {63'd0, q}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold1", {63'd0, q}, 64'd1);
      end

      // Load 0, then toggle 1,0,1.
      d = 1'b0;
      tick();
      check("load0", {63'd0, q}, 64'd0);
      d = 1'b1;
      tick();
      check("tog_a", {63'd0, q}, 64'd1);
      d = 1'b0;
      tick();
      check("tog_b", {63'd0, q}, 64'd0);
      d = 1'b1;
      tick();
      check("tog_c", {63'd0, q}, 64'd1);

      // Change d between edges: q must wait for the next rising edge.
      @(negedge clk);
      d = 1'b0;
      #1;
      check("mid_edge_hold", {63'd0, q}, 64'd1);
      tick();
      check("mid_edge_load", {63'd0, q}, 64'd0);

      // Reset mid-operation with q=1.
      d = 1'b1;
      tick();
      check("pre_reset", {63'd0, q}, 64'd1);
      reset = 1'b1;
      #10;
      check("reset_no_async", {63'd0, q}, 64'd1);
      tick();
      check("reset_clear", {63'd0, q}, 64'd0);
      d = 1'bx;
      tick();
      check("reset_masks_x", {63'd0, q}, 64'd0);
      reset = 1'b0;
      d     = 1'b1;
      tick();
      check("deassert_load", {63'd0, q}, 64'd1);

      // X on d without reset propagates.
      d = 1'bx;
      tick();
      check("x_propagates", {63'd0, q}, {63'd0, 1'bx});
      d = 1'b0;
      tick();
      check("x_recover", {63'd0, q}, 64'd0);

      // 64-wide register built from replicated cells.
      d_arr = 64'd69;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("arr_69", q_arr, 64'd69);
      end
      d_arr = 64'd469;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("arr_469", q_arr, 64'd469);
      end
      reset = 1'b1;
      tick();
      check("arr_reset", q_arr, 64'd0);
      reset = 1'b0;
      d_arr = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      check("arr_ones", q_arr, 64'hFFFF_FFFF_FFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
